hex_digit_scan_driver: RTL and testbench
========================================

Name: hex_digit_scan_driver

Overview:
- Consumes the 16-bit hex-digit value produced by the memory-mapped hex-digit output register.
- Drives a 4-digit multiplexed 7-segment display: scan prescaler, digit rotation, frame-synchronous value capture, PWM brightness and hex-to-segment decode.
- Sits between the SoC register output and the board display pins.

Parameters:
- CLK_DIV, 50000: clk cycles per digit slot; minimum 16; values below 16 are illegal.
- ACTIVE_LOW, 1: 1 = segments and digit enables are active-low at the pins; 0 = active-high.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- hex_value  in  16  four nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- enable  in  1  display on/off.
- brightness  in  4  PWM duty in sixteenths; 0 = dark.
- seg  out  7  segments, bit0 = a through bit6 = g.
- dig_sel  out  4  one-hot digit enable; bit n = digit n.
- frame_tick  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset (async, any time including mid-slot):
  - prescaler = 0, digit index = 0, shadow = 0, frame_tick = 0.
  - seg and dig_sel are driven to the inactive level (all 1s if ACTIVE_LOW = 1, else all 0s) immediately, with no clock.
- Prescaler:
  - Counts 0 to CLK_DIV-1 and wraps to 0.
  - slot_end is asserted when the prescaler equals CLK_DIV-1.
- Digit index:
  - 2-bit; increments on slot_end; wraps 3 to 0.
  - On the 3-to-0 wrap, in the same edge: shadow <= hex_value and frame_tick = 1 for exactly one cycle.
  - Displayed data therefore changes only at frame boundaries; hex_value changes mid-frame are not visible until the next frame.
- PWM / dead time:
  - Digit is lit iff 1 <= prescaler[3:0] <= brightness.
  - This gives dead time at prescaler[3:0] = 0 (anti-ghosting).
  - brightness = 15 gives 15/16 duty; brightness = 0 never lights.
- Decode, gfedcba for active-high:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07.
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - ACTIVE_LOW = 1 inverts both seg and dig_sel.
- Output timing:
  - seg and dig_sel are registered: 1-cycle latency from counter state to pins.
  - When the digit is unlit, seg and dig_sel are both inactive.
- enable = 0:
  - Prescaler and index are held at 0; shadow loads hex_value every cycle.
  - Outputs are inactive; frame_tick = 0.
  - First enabled cycle starts the slot for digit 0 at prescaler 0.
- Simultaneous events:
  - enable falling on slot_end: enable wins, counters go to 0, no frame_tick.
  - brightness changes apply on the next cycle, with no glitch beyond one registered cycle.

Optional Feature:
- Macro: HEX_LEADING_ZERO_BLANK_EN.
- Defined: digits 3..1 are blanked (seg and dig_sel inactive for the whole slot) when that digit's shadow nibble and all higher nibbles are zero. Digit 0 is always shown. Slot timing and frame_tick are unchanged.
- Undefined: all four digits are always displayed, including leading zeros.

Test Plan:
1. CLK_DIV=16, ACTIVE_LOW=0, brightness=15, hex_value=16'h1234, enable=1 → digit order 0,1,2,3 with seg 66, 4F, 5B, 06. Each digit lit 15 of 16 cycles. frame_tick every 64 cycles.
2. Change hex_value from 16'h1234 to 16'hABCD during digit 1's slot → digits 2 and 3 still show 2 and 1. The following frame shows 0D=5E, 0C=39, 0B=7C, 0A=77.
3. brightness=4 → dig_sel active exactly at prescaler[3:0] = 1..4 (4 of 16 cycles). brightness=0 → dig_sel never active.
4. Assert reset mid-slot (prescaler = 7, digit 2) → seg and dig_sel inactive with no clock edge. After release, the first lit digit is digit 0. frame_tick fires after 64 cycles.
5. enable low for 100 cycles → outputs inactive, no frame_tick. On re-enable with hex_value=16'h00F0, digit 0 displays 3F at once (latency 1).
6. With HEX_LEADING_ZERO_BLANK_EN and hex_value=16'h0050 → digits 3 and 2 dark, digit 1 = 6D, digit 0 = 3F. With 16'h0000 → only digit 0 = 3F. Without the macro, all four digits are lit.

Source files
------------

// File: rtl/hex_digit_scan_driver.sv
// hex_digit_scan_driver
//
// Scans a 4-digit multiplexed 7-segment display from a 16-bit hex value.
// A prescaler divides clk into digit slots of CLK_DIV cycles. A 2-bit digit
// index rotates 0..3 through the slots. hex_value is captured into a shadow
// register only at the frame wrap, so a frame never shows a mix of old and
// new digits. Within each slot the digit is lit while 1 <= prescaler[3:0] <=
// brightness. The cycle at prescaler[3:0] = 0 is therefore always dark, which
// suppresses ghosting between adjacent digits.
//
// Parameters:
//   CLK_DIV    clk cycles per digit slot (must be >= 16)
//   ACTIVE_LOW 1: seg/dig_sel active-low at the pins, 0: active-high
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-high reset
//   hex_value   four nibbles, [3:0] = digit 0 (rightmost), [15:12] = digit 3
//   enable      display on/off; when low, counters are held at 0 and the
//               shadow register tracks hex_value
//   brightness  PWM duty in sixteenths, 0 = dark
//   seg         segments, bit0 = a .. bit6 = g (registered)
//   dig_sel     one-hot digit enable, bit n = digit n (registered)
//   frame_tick  one-cycle pulse after each frame wrap
//
// Optional feature, macro HEX_LEADING_ZERO_BLANK_EN:
//   When defined, digits 3..1 are dark for the whole slot if that digit's
//   shadow nibble and all higher nibbles are zero. Digit 0 is always shown.

module hex_digit_scan_driver #(
  parameter int unsigned CLK_DIV    = 50000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] hex_value,
  input  logic        enable,
  input  logic [3:0]  brightness,
  output logic [6:0]  seg,
  output logic [3:0]  dig_sel,
  output logic        frame_tick
);

  // Prescaler is at least 4 bits wide so that prescaler[3:0] always exists.
  localparam int unsigned PW = ($clog2(CLK_DIV) < 4) ? 4 : $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  // Pin levels for "off".
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] DIG_OFF = ACTIVE_LOW ? 4'hF : 4'h0;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          tick_q, tick_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    dig_q, dig_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic       slot_end;
  logic       frame_wrap;
  logic [3:0] nibble;
  logic [6:0] seg_raw;
  logic [3:0] dig_raw;
  logic       pwm_on;
  logic       digit_blank;
  logic       lit;

  assign slot_end   = (presc_q == PRESC_MAX);
  assign frame_wrap = slot_end && (idx_q == 2'd3);

  // Nibble of the digit currently being scanned.
  assign nibble = shadow_q[{idx_q, 2'b00} +: 4];

  // Hex to segments, gfedcba, active-high.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign seg_raw = hex_to_seg(nibble);

  always_comb begin
    dig_raw = 4'h0;
    case (idx_q)
      2'd0:    dig_raw = 4'b0001;
      2'd1:    dig_raw = 4'b0010;
      2'd2:    dig_raw = 4'b0100;
      default: dig_raw = 4'b1000;
    endcase
  end

  // Dead time at prescaler[3:0] == 0, then lit for `brightness` cycles of 16.
  assign pwm_on = (presc_q[3:0] != 4'h0) && (presc_q[3:0] <= brightness);

`ifdef HEX_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit to its left are zero.
  always_comb begin
    digit_blank = 1'b0;
    case (idx_q)
      2'd3:    digit_blank = (shadow_q[15:12] == 4'h0);
      2'd2:    digit_blank = (shadow_q[15:8] == 8'h00);
      2'd1:    digit_blank = (shadow_q[15:4] == 12'h000);
      default: digit_blank = 1'b0;
    endcase
  end
`else
  assign digit_blank = 1'b0;
`endif

  assign lit = enable && pwm_on && !digit_blank;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    presc_d  = presc_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    tick_d   = 1'b0;

    if (!enable) begin
      // Disabled: hold at the start of digit 0 and keep the shadow current, so
      // re-enabling shows the present value immediately. This also wins over a
      // coincident slot_end, so no frame_tick is produced then.
      presc_d  = '0;
      idx_d    = 2'd0;
      shadow_d = hex_value;
    end else if (slot_end) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
      if (frame_wrap) begin
        shadow_d = hex_value;
        tick_d   = 1'b1;
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Pin-level outputs, registered from the current counter state.
  always_comb begin
    seg_d = SEG_OFF;
    dig_d = DIG_OFF;
    if (lit) begin
      seg_d = ACTIVE_LOW ? ~seg_raw : seg_raw;
      dig_d = ACTIVE_LOW ? ~dig_raw : dig_raw;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q  <= '0;
      idx_q    <= 2'd0;
      shadow_q <= 16'h0000;
      tick_q   <= 1'b0;
      seg_q    <= SEG_OFF;
      dig_q    <= DIG_OFF;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      tick_q   <= tick_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
    end
  end

  assign seg        = seg_q;
  assign dig_sel    = dig_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_hex_digit_scan_driver.sv
// Directed bench for hex_digit_scan_driver with CLK_DIV = 16, ACTIVE_LOW = 0.
// Outputs are sampled 1 time unit after each rising clock edge. After edge n
// of a frame (n = 1..64), the outputs reflect the counter state before that
// edge: prescaler (n-1)%16 and digit (n-1)/16.

module tb_hex_digit_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] hex_value;
  logic        enable;
  logic [3:0]  brightness;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic        frame_tick;

  int tests = 0;
  int fails = 0;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  always #5 clk = ~clk;

  hex_digit_scan_driver #(
    .CLK_DIV   (16),
    .ACTIVE_LOW(1'b0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .hex_value (hex_value),
    .enable    (enable),
    .brightness(brightness),
    .seg       (seg),
    .dig_sel   (dig_sel),
    .frame_tick(frame_tick)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one full frame from prescaler 0 / digit 0, checking every cycle.
  // `shown` is the shadow value expected for this frame. hex_value is changed
  // to new_hex after edge change_at (0 = no change).
  task automatic run_frame(input string tag, input logic [15:0] shown, input logic [3:0] br,
                           input int change_at, input logic [15:0] new_hex);
    brightness = br;
    for (int n = 1; n <= 64; n++) begin
      int         p;
      int         d;
      logic       on;
      logic [3:0] nib;
      logic [6:0] es;
      logic [3:0] ed;
      tick();
      if (n == change_at) hex_value = new_hex;
      p   = (n - 1) % 16;
      d   = (n - 1) / 16;
      on  = (p >= 1) && (p <= int'(br));
      nib = 4'((shown >> (4 * d)) & 16'hF);
`ifdef HEX_LEADING_ZERO_BLANK_EN
      if (d > 0 && (shown >> (4 * d)) == 16'h0) on = 1'b0;
`endif
      es = on ? SEG_TAB[nib] : 7'h00;
      ed = on ? 4'(1 << d) : 4'h0;
      chk({tag, " seg"}, {9'h0, seg}, {9'h0, es});
      chk({tag, " dig_sel"}, {12'h0, dig_sel}, {12'h0, ed});
      chk({tag, " frame_tick"}, {15'h0, frame_tick}, {15'h0, (n == 64)});
    end
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    brightness = 4'd15;
    hex_value  = 16'h1234;

    // Reset state, before any clock edge.
    #3;
    chk("reset seg", {9'h0, seg}, 16'h0);
    chk("reset dig_sel", {12'h0, dig_sel}, 16'h0);
    chk("reset frame_tick", {15'h0, frame_tick}, 16'h0);

    tick();
    reset = 1'b0;
    tick();
    chk("disabled seg", {9'h0, seg}, 16'h0);
    chk("disabled dig_sel", {12'h0, dig_sel}, 16'h0);

    // Test 1 + 2: 1234 shown, change to ABCD during digit 1 slot.
    enable = 1'b1;
    run_frame("t1", 16'h1234, 4'd15, 20, 16'hABCD);
    run_frame("t2", 16'hABCD, 4'd15, 0, 16'h0);

    // Test 3: PWM duty.
    run_frame("t3 br4", 16'hABCD, 4'd4, 0, 16'h0);
    run_frame("t3 br0", 16'hABCD, 4'd0, 0, 16'h0);

    // Test 4: async reset at prescaler 7, digit 2.
    brightness = 4'd15;
    repeat (39) tick();
    chk("t4 pre-reset seg", {9'h0, seg}, 16'h007C);
    chk("t4 pre-reset dig_sel", {12'h0, dig_sel}, 16'h0004);
    #2;
    reset = 1'b1;
    #1;
    chk("t4 async seg", {9'h0, seg}, 16'h0);
    chk("t4 async dig_sel", {12'h0, dig_sel}, 16'h0);
    tick();
    reset = 1'b0;
    run_frame("t4 post", 16'h0000, 4'd15, 0, 16'h0);

    // Test 5: disabled for 100 cycles, then re-enable with 00F0.
    enable    = 1'b0;
    hex_value = 16'h00F0;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("t5 off seg", {9'h0, seg}, 16'h0);
      chk("t5 off dig_sel", {12'h0, dig_sel}, 16'h0);
      chk("t5 off frame_tick", {15'h0, frame_tick}, 16'h0);
    end
    enable = 1'b1;
    run_frame("t5 on", 16'h00F0, 4'd15, 5, 16'h0050);

    // Test 6: leading zeros.
    run_frame("t6 0050", 16'h0050, 4'd15, 5, 16'h0000);
    run_frame("t6 0000", 16'h0000, 4'd15, 0, 16'h0);

    // enable falls exactly on the frame-wrap slot_end: no frame_tick.
    repeat (63) tick();
    enable    = 1'b0;
    hex_value = 16'h1234;
    tick();
    chk("t7 wrap frame_tick", {15'h0, frame_tick}, 16'h0);
    chk("t7 wrap dig_sel", {12'h0, dig_sel}, 16'h0);
    tick();
    chk("t7 held frame_tick", {15'h0, frame_tick}, 16'h0);
    enable = 1'b1;
    run_frame("t7 resume", 16'h1234, 4'd15, 0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
